program_loader: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/byte_packer.sv | 32 +++
 rtl/program_loader.sv | 114 +++++++++++
 tb/tb_program_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and the opcode field layout
// used by both the program loader and the instruction decoder.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RX_HI = 3'd1,
      RX_LO = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int unsigned OPC_MSB  = 15;
   localparam int unsigned OPC_LSB  = 11;
   localparam logic [4:0]  OPC_HALT = 5'b00000;

endpackage

// File: rtl/byte_packer.sv
// Assembles two consecutive bytes into a 16-bit word, high byte first.
// o_valid pulses for one cycle after the low byte has been captured.
module byte_packer (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load_hi,
   input  logic        i_load_lo,
   input  logic [7:0]  i_byte,
   output logic [15:0] o_word,
   output logic        o_valid
);

   logic [7:0] hi_q;
   logic [7:0] lo_q;
   logic       valid_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         hi_q    <= '0;
         lo_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         if (i_load_hi) hi_q <= i_byte;
         if (i_load_lo) lo_q <= i_byte;
         valid_q <= i_load_lo;
      end
   end

   assign o_word  = {hi_q, lo_q};
   assign o_valid = valid_q;

endmodule

// File: rtl/program_loader.sv
// Writes a byte-streamed program into CPU program memory at sequential
// addresses, holding the CPU in reset until a halt word or memory full.
module program_loader
   import cpu_pkg::*;
#(
   parameter int unsigned NBITS_O   = 11,
   parameter int unsigned NBITS_D   = 16,
   parameter int unsigned CELDAS    = 10,
   parameter int unsigned NBITS_OPC = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_wr_en,
   output logic [NBITS_O-1:0] o_wr_addr,
   output logic [NBITS_D-1:0] o_wr_data,
   output logic               o_cpu_hold,
   output logic               o_done,
   output logic               o_overrun,
   output logic [NBITS_O-1:0] o_word_count
);

   localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

   state_e               state_q;
   logic [NBITS_O-1:0]   addr_q;
   logic [NBITS_O-1:0]   wr_addr_q;
   logic [NBITS_O-1:0]   count_q;
   logic                 hold_q;
   logic                 done_q;
   logic                 overrun_q;

   logic                 load_hi;
   logic                 load_lo;
   logic [15:0]          word;
   logic                 word_valid;
   logic [NBITS_OPC-1:0] opcode;
   logic                 halt;

   assign load_hi = (state_q == RX_HI) && i_rx_valid;
   assign load_lo = (state_q == RX_LO) && i_rx_valid;

   byte_packer u_packer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load_hi (load_hi),
      .i_load_lo (load_lo),
      .i_byte    (i_rx_data),
      .o_word    (word),
      .o_valid   (word_valid)
   );

   assign opcode = word[OPC_MSB:OPC_LSB];
   assign halt   = (opcode == OPC_HALT);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wr_addr_q <= '0;
         count_q   <= '0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               // A start in the same cycle as a byte wins; the byte is discarded.
               if (i_start) begin
                  state_q   <= RX_HI;
                  addr_q    <= '0;
                  count_q   <= '0;
                  hold_q    <= 1'b1;
                  done_q    <= 1'b0;
                  overrun_q <= 1'b0;
               end
            end
            RX_HI: begin
               if (i_rx_valid) state_q <= RX_LO;
            end
            RX_LO: begin
               if (i_rx_valid) begin
                  state_q   <= WRITE;
                  wr_addr_q <= addr_q;
               end
            end
            WRITE: begin
               count_q <= count_q + 1'b1;
               if (i_rx_valid) overrun_q <= 1'b1;
               if (halt || (addr_q == LAST_ADDR)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  hold_q  <= 1'b0;
               end else begin
                  state_q <= RX_HI;
                  addr_q  <= addr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_wr_en      = word_valid;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = NBITS_D'(word);
   assign o_cpu_hold   = hold_q;
   assign o_done       = done_q;
   assign o_overrun    = overrun_q;
   assign o_word_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, restart, ignore rules,
// memory full, overrun and asynchronous reset in the middle of a load.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [15:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        overrun;
   logic [10:0] word_count;

   int checks = 0;
   int errors = 0;

   logic [10:0] log_addr [0:63];
   logic [15:0] log_data [0:63];
   int          wr_n = 0;
   int          long_pulse = 0;
   logic        wr_en_prev = 1'b0;

   program_loader #(
      .NBITS_O   (11),
      .NBITS_D   (16),
      .CELDAS    (10),
      .NBITS_OPC (5)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_cpu_hold   (cpu_hold),
      .o_done       (done),
      .o_overrun    (overrun),
      .o_word_count (word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_n < 64) begin
            log_addr[wr_n] = wr_addr;
            log_data[wr_n] = wr_data;
         end
         wr_n = wr_n + 1;
         if (wr_en_prev) long_pulse = long_pulse + 1;
      end
      wr_en_prev = wr_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   int base;

   initial begin
      // ---- reset state
      repeat (2) @(negedge clk);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_addr", 32'(wr_addr), 0);
      chk("rst_data", 32'(wr_data), 0);
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_cnt", 32'(word_count), 0);
      rst = 1'b0;

      // ---- bytes in IDLE are ignored
      send_byte(8'h55);
      send_byte(8'hAA);
      @(negedge clk);
      chk("idle_no_wr", 32'(wr_n), 0);
      chk("idle_no_ovr", 32'(overrun), 0);
      chk("idle_no_hold", 32'(cpu_hold), 0);

      // ---- normal load
      base = wr_n;
      pulse_start();
      chk("nl_hold", 32'(cpu_hold), 1);
      send_word(16'h1001);
      chk("nl_w0_en", 32'(wr_en), 1);
      chk("nl_w0_addr", 32'(wr_addr), 0);
      chk("nl_w0_data", 32'(wr_data), 32'h1001);
      send_word(16'h2802);
      send_word(16'h0000);
      chk("nl_w2_en", 32'(wr_en), 1);
      chk("nl_w2_addr", 32'(wr_addr), 2);
      chk("nl_w2_hold", 32'(cpu_hold), 1);
      chk("nl_w2_done", 32'(done), 0);
      @(negedge clk);
      chk("nl_done", 32'(done), 1);
      chk("nl_hold_fall", 32'(cpu_hold), 0);
      chk("nl_en_fall", 32'(wr_en), 0);
      chk("nl_cnt", 32'(word_count), 3);
      repeat (3) @(negedge clk);
      chk("nl_pulses", 32'(wr_n - base), 3);
      chk("nl_log1_addr", 32'(log_addr[base+1]), 1);
      chk("nl_log1_data", 32'(log_data[base+1]), 32'h2802);
      chk("nl_log2_data", 32'(log_data[base+2]), 32'h0000);
      chk("nl_done_sticky", 32'(done), 1);

      // ---- bytes in DONE are ignored
      base = wr_n;
      send_word(16'h1234);
      @(negedge clk);
      chk("done_no_wr", 32'(wr_n - base), 0);
      chk("done_no_ovr", 32'(overrun), 0);

      // ---- restart from DONE
      pulse_start();
      chk("rs_done_drop", 32'(done), 0);
      chk("rs_cnt_clr", 32'(word_count), 0);
      send_word(16'h0000);
      chk("rs_addr", 32'(wr_addr), 0);
      chk("rs_data", 32'(wr_data), 0);
      @(negedge clk);
      chk("rs_done", 32'(done), 1);
      chk("rs_cnt", 32'(word_count), 1);

      // ---- start during RX_LO is ignored
      pulse_start();
      send_word(16'h0801);
      send_byte(8'h08);
      pulse_start();
      send_byte(8'h02);
      chk("ig_addr", 32'(wr_addr), 1);
      chk("ig_data", 32'(wr_data), 32'h0802);
      chk("ig_hold", 32'(cpu_hold), 1);

      // ---- memory full: continue this load to 10 words, no halt
      for (int i = 2; i < 10; i++) send_word(16'h0801);
      chk("mf_last_addr", 32'(wr_addr), 9);
      chk("mf_last_en", 32'(wr_en), 1);
      @(negedge clk);
      chk("mf_done", 32'(done), 1);
      chk("mf_cnt", 32'(word_count), 10);
      base = wr_n;
      send_word(16'h0801);
      @(negedge clk);
      chk("mf_no_11th", 32'(wr_n - base), 0);
      chk("mf_cnt_hold", 32'(word_count), 10);

      // ---- overrun
      pulse_start();
      send_word(16'h1001);
      rx_data  = 8'hEE;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("ov_flag", 32'(overrun), 1);
      send_word(16'h2802);
      chk("ov_w1_addr", 32'(wr_addr), 1);
      chk("ov_w1_data", 32'(wr_data), 32'h2802);
      send_word(16'h0000);
      @(negedge clk);
      chk("ov_sticky", 32'(overrun), 1);
      chk("ov_done", 32'(done), 1);
      pulse_start();
      chk("ov_clear", 32'(overrun), 0);

      // ---- asynchronous reset mid-load (load already running, set overrun first)
      send_word(16'h0801);
      rx_data  = 8'hEE;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      send_byte(8'h10);
      chk("ar_pre_hold", 32'(cpu_hold), 1);
      chk("ar_pre_ovr", 32'(overrun), 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_hold", 32'(cpu_hold), 0);
      chk("ar_ovr", 32'(overrun), 0);
      chk("ar_cnt", 32'(word_count), 0);
      chk("ar_addr", 32'(wr_addr), 0);
      chk("ar_data", 32'(wr_data), 0);
      chk("ar_en", 32'(wr_en), 0);
      chk("ar_done", 32'(done), 0);
      rst = 1'b0;
      base = wr_n;
      pulse_start();
      send_word(16'h2A00);
      chk("ar_w0_addr", 32'(wr_addr), 0);
      chk("ar_w0_data", 32'(wr_data), 32'h2A00);
      send_word(16'h0000);
      @(negedge clk);
      chk("ar_done_end", 32'(done), 1);
      chk("ar_cnt_end", 32'(word_count), 2);
      chk("ar_pulses", 32'(wr_n - base), 2);

      repeat (2) @(negedge clk);
      chk("single_cycle_wr", 32'(long_pulse), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
